// File: rtl/vga_pkg.sv
// Shared constants for the VGA display path: frame geometry, bus widths, fetch FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vga_pkg;

  // Address/data widths of the video memory arbiter ports.
  localparam int unsigned VGA_AWIDTH = 19;
  localparam int unsigned VGA_DWIDTH = 8;

  // Default frame: 640x480 at one byte per pixel.
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned FB_PIXELS = H_ACTIVE * V_ACTIVE;

  // Fetch FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous single-clock pixel FIFO with flush and registered read data.
// Latency: dout_o updates on the edge after pop_i; level_o/full_o/empty_o are registered occupancy.
// Backpressure: push_i is dropped when full unless a pop happens in the same cycle; pop_i on empty
//   loads zero into dout_o and leaves the FIFO untouched.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i empties the FIFO;
//   push_i/din_i write side; pop_i/dout_o read side; level_o/full_o/empty_o status.
module pix_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  import vga_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] dout_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o && !flush_i;
  // When full, the slot being written is the one being read this edge, so push is safe with a pop.
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    level_d = level_q;
    if (flush_i) begin
      level_d = '0;
    end else if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      level_q <= level_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (pop_i)   dout_q   <= empty_o ? '0 : mem_q[rd_ptr_q];
      end
    end
  end

  // Storage has no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = dout_q;
  assign level_o = level_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch for the display read channel: drives the read address, buffers returned bytes,
//   hands one pixel per PixelReq to the timing stage, tracks frame progress and flags underrun.
// Latency: PixelData/PixelValid one cycle after PixelReq; ReqAddr advances on the accepting edge.
// Backpressure: a returned byte is dropped while the FIFO is full (no pop) and ReqAddr holds so the
//   same address is re-read; PixelReq on an empty FIFO gives PixelValid=0, PixelData=0, sticky Underrun.
// Ports: MemClk/ResetN clock and async active-low reset; FrameStart restarts the frame;
//   ReadData/ReadDataRdy from arbiter; ReqAddr to arbiter; PixelReq/PixelData/PixelValid to timing
//   stage; Underrun, FifoLevel, FrameDone status.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned AWIDTH     = VGA_AWIDTH,
  parameter int unsigned DWIDTH     = VGA_DWIDTH,
  parameter int unsigned FB_BASE    = 0,
  parameter int unsigned FB_PIXELS  = vga_pkg::FB_PIXELS,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          MemClk,
  input  logic                          ResetN,
  input  logic                          FrameStart,
  input  logic [DWIDTH-1:0]             ReadData,
  input  logic                          ReadDataRdy,
  output logic [AWIDTH-1:0]             ReqAddr,
  input  logic                          PixelReq,
  output logic [DWIDTH-1:0]             PixelData,
  output logic                          PixelValid,
  output logic                          Underrun,
  output logic [$clog2(FIFO_DEPTH):0]   FifoLevel,
  output logic                          FrameDone
);

  localparam int unsigned   CW        = $clog2(FB_PIXELS + 1);
  localparam logic [AWIDTH-1:0] ADDR_BASE = AWIDTH'(FB_BASE);
  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(FB_BASE + FB_PIXELS - 1);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(FB_PIXELS - 1);

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              underrun_q, underrun_d;
  logic              valid_q;

  logic fifo_full, fifo_empty;
  logic pop_req, pop_ok, accept;

  // FrameStart wins over everything else in its cycle.
  assign pop_req = PixelReq && !FrameStart;
  assign pop_ok  = pop_req && !fifo_empty;
  assign accept  = (state_q == ST_FETCH) && ReadDataRdy && !FrameStart && (!fifo_full || pop_ok);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    if (FrameStart) begin
      state_d    = ST_FETCH;
      addr_d     = ADDR_BASE;
      cnt_d      = '0;
      underrun_d = 1'b0;
    end else begin
      if (pop_req && fifo_empty) underrun_d = 1'b1;
      case (state_q)
        ST_IDLE: ;
        ST_FETCH: begin
          if (accept) begin
            addr_d = (addr_q == ADDR_LAST) ? ADDR_BASE : addr_q + AWIDTH'(1);
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = ST_DONE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge MemClk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_BASE;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      valid_q    <= pop_ok;
    end
  end

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DWIDTH)
  ) u_fifo (
    .clk_i   (MemClk),
    .rst_ni  (ResetN),
    .flush_i (FrameStart),
    .push_i  (accept),
    .pop_i   (pop_req),
    .din_i   (ReadData),
    .dout_o  (PixelData),
    .level_o (FifoLevel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ReqAddr    = addr_q;
  assign PixelValid = valid_q;
  assign Underrun   = underrun_q;
  assign FrameDone  = (state_q == ST_DONE);

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: a full-size instance and a FB_PIXELS=8 instance share stimulus.
module tb_vga_pixel_fetch;

  logic       MemClk = 1'b0;
  logic       ResetN;
  logic       FrameStart;
  logic [7:0] ReadData;
  logic       ReadDataRdy;
  logic       PixelReq;

  logic [18:0] ReqAddr,   ReqAddr8;
  logic [7:0]  PixelData, PixelData8;
  logic        PixelValid, PixelValid8;
  logic        Underrun,  Underrun8;
  logic [4:0]  FifoLevel, FifoLevel8;
  logic        FrameDone, FrameDone8;

  int checks   = 0;
  int failures = 0;

  always #5 MemClk = ~MemClk;

  vga_pixel_fetch u_dut (
    .MemClk(MemClk), .ResetN(ResetN), .FrameStart(FrameStart),
    .ReadData(ReadData), .ReadDataRdy(ReadDataRdy), .ReqAddr(ReqAddr),
    .PixelReq(PixelReq), .PixelData(PixelData), .PixelValid(PixelValid),
    .Underrun(Underrun), .FifoLevel(FifoLevel), .FrameDone(FrameDone)
  );

  vga_pixel_fetch #(.FB_PIXELS(8)) u_dut8 (
    .MemClk(MemClk), .ResetN(ResetN), .FrameStart(FrameStart),
    .ReadData(ReadData), .ReadDataRdy(ReadDataRdy), .ReqAddr(ReqAddr8),
    .PixelReq(PixelReq), .PixelData(PixelData8), .PixelValid(PixelValid8),
    .Underrun(Underrun8), .FifoLevel(FifoLevel8), .FrameDone(FrameDone8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs held across the edge; outputs sampled 1ns after it.
  task automatic cyc(input logic fs, input logic rdy, input logic [7:0] d, input logic req);
    FrameStart  = fs;
    ReadDataRdy = rdy;
    ReadData    = d;
    PixelReq    = req;
    @(posedge MemClk);
    #1;
    FrameStart  = 1'b0;
    ReadDataRdy = 1'b0;
    PixelReq    = 1'b0;
  endtask

  initial begin
    ResetN = 1'b0; FrameStart = 1'b0; ReadData = 8'h00; ReadDataRdy = 1'b0; PixelReq = 1'b0;
    repeat (2) @(posedge MemClk);
    #1;
    chk("rst_addr",  32'(ReqAddr), 32'd0);
    chk("rst_level", 32'(FifoLevel), 32'd0);
    chk("rst_valid", 32'(PixelValid), 32'd0);
    chk("rst_data",  32'(PixelData), 32'd0);
    chk("rst_under", 32'(Underrun), 32'd0);
    chk("rst_done",  32'(FrameDone), 32'd0);
    ResetN = 1'b1;

    // IDLE ignores returned data.
    cyc(1'b0, 1'b1, 8'h99, 1'b0);
    chk("idle_level", 32'(FifoLevel), 32'd0);
    chk("idle_addr",  32'(ReqAddr), 32'd0);

    // Four bytes in, four pixels out in order.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    chk("t1_addr",  32'(ReqAddr), 32'd4);
    chk("t1_level", 32'(FifoLevel), 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t1_valid", 32'(PixelValid), 32'd1);
      chk("t1_data",  32'(PixelData), 32'(8'h11 * (i + 1)));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_valid_drop", 32'(PixelValid), 32'd0);
    chk("t1_level_end",  32'(FifoLevel), 32'd0);

    // Fill to full, drop on full, then simultaneous push/pop.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
    chk("t2_full_level", 32'(FifoLevel), 32'd16);
    chk("t2_full_addr",  32'(ReqAddr), 32'd16);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("t2_drop_level", 32'(FifoLevel), 32'd16);
    chk("t2_drop_addr",  32'(ReqAddr), 32'd16);
    cyc(1'b0, 1'b1, 8'hBB, 1'b1);
    chk("t2_pp_level", 32'(FifoLevel), 32'd16);
    chk("t2_pp_addr",  32'(ReqAddr), 32'd17);
    chk("t2_pp_data",  32'(PixelData), 32'h50);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("t2_drain_valid", 32'(PixelValid), 32'd1);
      chk("t2_drain_data",  32'(PixelData), (i == 15) ? 32'hBB : 32'(8'h51 + i));
    end
    chk("t2_empty", 32'(FifoLevel), 32'd0);

    // Underrun: zero data, sticky across a same-cycle push, cleared by FrameStart.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t3_valid", 32'(PixelValid), 32'd0);
    chk("t3_data",  32'(PixelData), 32'd0);
    chk("t3_under", 32'(Underrun), 32'd1);
    cyc(1'b0, 1'b1, 8'hC1, 1'b1);
    chk("t3_nobypass_valid", 32'(PixelValid), 32'd0);
    chk("t3_nobypass_level", 32'(FifoLevel), 32'd1);
    chk("t3_under_hold",     32'(Underrun), 32'd1);
    cyc(1'b0, 1'b1, 8'hC2, 1'b0);
    chk("t3_under_hold2", 32'(Underrun), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("t3_under_clr", 32'(Underrun), 32'd0);
    chk("t3_fs_level",  32'(FifoLevel), 32'd0);
    chk("t3_fs_addr",   32'(ReqAddr), 32'd0);

    // Frame end on the 8-pixel instance.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'(8'hE0 + i), 1'b1);
      if (i == 6) begin
        chk("t4_addr7", 32'(ReqAddr8), 32'd7);
        chk("t4_notdone", 32'(FrameDone8), 32'd0);
      end
      if (i == 7) begin
        chk("t4_done", 32'(FrameDone8), 32'd1);
        chk("t4_wrap", 32'(ReqAddr8), 32'd0);
      end
      if (i == 8) chk("t4_tail_valid", 32'(PixelValid8), 32'd1);
    end
    chk("t4_done_hold", 32'(FrameDone8), 32'd1);
    chk("t4_addr_hold", 32'(ReqAddr8), 32'd0);
    chk("t4_level",     32'(FifoLevel8), 32'd0);
    chk("t4_big_addr",  32'(ReqAddr), 32'd10);

    // FrameStart mid-frame at level 5, address 37.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 37; i++) cyc(1'b0, 1'b1, 8'(i), (i >= 1 && i <= 32));
    chk("t5_level", 32'(FifoLevel), 32'd5);
    chk("t5_addr",  32'(ReqAddr), 32'd37);
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    chk("t5_fs_level", 32'(FifoLevel), 32'd0);
    chk("t5_fs_addr",  32'(ReqAddr), 32'd0);
    chk("t5_fs_done",  32'(FrameDone), 32'd0);
    chk("t5_fs_done8", 32'(FrameDone8), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_not_stored", 32'(FifoLevel), 32'd0);

    // Asynchronous reset between edges.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 1'b1, 8'h6B, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_pre_valid", 32'(PixelValid), 32'd1);
    chk("t6_pre_data",  32'(PixelData), 32'h5A);
    chk("t6_pre_under", 32'(Underrun), 32'd1);
    #2;
    ResetN = 1'b0;
    #1;
    chk("t6_addr",  32'(ReqAddr), 32'd0);
    chk("t6_level", 32'(FifoLevel), 32'd0);
    chk("t6_valid", 32'(PixelValid), 32'd0);
    chk("t6_data",  32'(PixelData), 32'd0);
    chk("t6_under", 32'(Underrun), 32'd0);
    chk("t6_done",  32'(FrameDone), 32'd0);
    ResetN = 1'b1;
    cyc(1'b0, 1'b1, 8'h12, 1'b0);
    cyc(1'b0, 1'b1, 8'h34, 1'b0);
    chk("t6_idle_level", 32'(FifoLevel), 32'd0);
    chk("t6_idle_addr",  32'(ReqAddr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
Sits directly downstream of the video memory arbiter on its read channel 1. Drives the address source that the arbiter samples for the display read slots. Collects returned framebuffer bytes into a small FIFO and hands one pixel byte per request to the VGA timing/output stage, all in the MemClk domain. Tracks the linear framebuffer address across a frame and flags underrun.

Parameters:
AWIDTH, 19, framebuffer address width; matches the arbiter address ports
DWIDTH, 8, pixel/data width
FB_BASE, 0, first framebuffer address of a frame
FB_PIXELS, 307200, bytes per frame (640x480 at 8 bpp)
FIFO_DEPTH, 16, pixel FIFO entries; power of two, at least 4

Ports:
MemClk  in  1  system/memory clock, rising edge
ResetN  in  1  asynchronous active-low reset
FrameStart  in  1  one-cycle pulse at start of vertical blank; restarts the frame fetch
ReadData  in  DWIDTH  byte returned by the arbiter (its ReqReadData1)
ReadDataRdy  in  1  one-cycle strobe; ReadData valid (its ReadDataRdy1)
ReqAddr  out  AWIDTH  fetch address to the arbiter (its ReqAddrSrc1)
PixelReq  in  1  one-cycle strobe from the timing stage, one per active pixel
PixelData  out  DWIDTH  pixel byte, registered
PixelValid  out  1  high for one cycle when PixelData was popped from the FIFO
Underrun  out  1  sticky; PixelReq arrived with the FIFO empty
FifoLevel  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
FrameDone  out  1  high once FB_PIXELS bytes have been accepted in this frame

Behaviour:
- Reset (async, ResetN low) sets state IDLE, ReqAddr=FB_BASE, PixelData=0, PixelValid=0, Underrun=0, FifoLevel=0, FrameDone=0, and the accepted-byte counter to 0.
- States:
  - IDLE: ignores ReadDataRdy; goes to FETCH on FrameStart.
  - FETCH: accepts bytes; goes to DONE when the accepted count reaches FB_PIXELS.
  - DONE: ignores ReadDataRdy; FrameDone=1; goes to FETCH on FrameStart.
- FrameStart, in any state, in the same edge:
  - flushes the FIFO (level 0) and sets ReqAddr=FB_BASE;
  - clears the count, FrameDone and Underrun;
  - enters FETCH.
  - ReadDataRdy and PixelReq in that cycle are ignored.
- Accept rule in FETCH: ReadDataRdy=1 and the FIFO is not full, or full with a pop in the same cycle.
  - Push ReadData.
  - ReqAddr <= ReqAddr+1; wraps to FB_BASE after FB_BASE+FB_PIXELS-1.
  - Count +1.
- Full FIFO without a pop: the byte is dropped and ReqAddr is held, so the same address is re-read at the arbiter's next read slot. No data loss, no address skip.
- ReqAddr changes only on the edge that accepts a byte. It is stable from there through the arbiter's next address-sample phase.
- Pop rule: PixelReq=1 and FifoLevel>0.
  - On the next edge, PixelData <= FIFO head and PixelValid=1 for one cycle (latency 1).
- PixelReq with FifoLevel=0:
  - PixelData <= 0 and PixelValid=0; Underrun set and held until FrameStart or reset.
  - There is no push-to-pop bypass: a same-cycle push into an empty FIFO still underruns, and the pushed byte is stored.
- Simultaneous push and pop: FifoLevel unchanged, and FIFO order is preserved.
- PixelReq in IDLE/DONE: popping continues while data remains, so the tail of the frame drains in DONE.
- FifoLevel is the registered occupancy and never exceeds FIFO_DEPTH.
- All arithmetic is unsigned. The accepted-byte counter is clog2(FB_PIXELS+1) bits.

Decomposition:
- Shared package vga_pkg holds:
  - fetch state encoding (IDLE=2'd0, FETCH=2'd1, DONE=2'd2);
  - default frame constants (H_ACTIVE=640, V_ACTIVE=480, FB_PIXELS);
  - the address/data width constants shared with the arbiter.
- One sub-module, pix_fifo: synchronous single-clock FIFO, DEPTH/WIDTH parameters, async active-low reset.
  - Ports: push, pop, din, dout, level, full, empty.
  - Registered dout on pop.
- The top level holds the FSM, address/counter logic and the underrun flag.

Test Plan:
1. Reset, then FrameStart, then 4 ReadDataRdy with bytes 0x11,0x22,0x33,0x44 -> ReqAddr 0→4, FifoLevel=4. Then 4 PixelReq -> PixelData 0x11..0x44, each with PixelValid the next cycle.
2. Fill to 16 with no PixelReq, then ReadDataRdy with 0xAA -> FifoLevel stays 16, ReqAddr stays 16, 0xAA absent on readout. Then PixelReq+ReadDataRdy(0xBB) same cycle -> level 16, ReqAddr=17, 0xBB is the 16th pixel read out.
3. PixelReq with an empty FIFO -> PixelValid=0, PixelData=0, Underrun=1; it stays 1 through later pushes until FrameStart clears it.
4. FB_PIXELS=8 build, 10 Rdy strobes with pixels drained -> FrameDone=1 after the 8th, ReqAddr wraps to FB_BASE, strobes 9–10 ignored, state DONE.
5. FrameStart mid-frame at level 5, ReqAddr=37 -> next cycle FifoLevel=0, ReqAddr=FB_BASE, FrameDone=0; a same-cycle Rdy is not stored.
6. Assert ResetN low asynchronously mid-FETCH between clock edges -> all outputs at reset values immediately. After release, no pushes occur until FrameStart.
